// File: rtl/mem_responder.sv
// Behavioural memory endpoint for the shared request/response interface: fixed-latency
// in-order responses from a word array, with periodic refresh windows that stall requesters.
module mem_responder #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int DEPTH          = 1024,
  parameter int LATENCY        = 3,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_wstrb,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            rsp_we
);

  localparam int SW  = DW / 8;
  localparam int OFF = $clog2(SW);
  localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RPW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int RCW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_NORMAL,
    ST_REFRESH
  } state_e;

  typedef struct packed {
    logic          vld;
    logic          we;
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  state_e         state_q, state_d;
  logic [RPW-1:0] ref_cnt_q, ref_cnt_d;
  logic [RCW-1:0] win_cnt_q, win_cnt_d;

  // ---------------------------------------------------------------------------
  // Control FSM: INIT for one cycle, then NORMAL/REFRESH alternation
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      ref_cnt_q <= '0;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ref_cnt_q <= ref_cnt_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    ref_cnt_d = ref_cnt_q;
    win_cnt_d = win_cnt_q;
    req_ready = 1'b0;
    unique case (state_q)
      ST_INIT: state_d = ST_NORMAL;
      ST_NORMAL: begin
        req_ready = 1'b1;
        if (REFRESH_PERIOD != 0 && ref_cnt_q == RPW'(REFRESH_PERIOD - 1)) begin
          state_d   = ST_REFRESH;
          ref_cnt_d = '0;
          win_cnt_d = '0;
        end else begin
          ref_cnt_d = ref_cnt_q + 1'b1;
        end
      end
      ST_REFRESH: begin
        if (win_cnt_q == RCW'(REFRESH_CYCLES - 1)) state_d = ST_NORMAL;
        else                                       win_cnt_d = win_cnt_q + 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address decode and backing store
  // ---------------------------------------------------------------------------
  logic          accept;
  logic [AW-1:0] word_idx;
  logic [MW-1:0] mem_idx;
  logic          in_range;
  logic [DW-1:0] mem [DEPTH];

  assign accept   = req_valid && req_ready;
  assign word_idx = req_addr >> OFF;
  assign mem_idx  = word_idx[MW-1:0];
  assign in_range = (64'(word_idx) < 64'(DEPTH));

  // NOTE: the storage array has no reset; only control and pipeline state are cleared.
  always_ff @(posedge clk) begin
    if (accept && req_we && in_range) begin
      for (int b = 0; b < SW; b++) begin
        if (req_wstrb[b]) mem[mem_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline: LATENCY stages, last stage drives the rsp_* outputs
  // ---------------------------------------------------------------------------
  rsp_t stage_in;
  rsp_t pipe_q [LATENCY];

  always_comb begin
    stage_in       = '0;
    stage_in.vld   = accept;
    stage_in.we    = accept && req_we;
    stage_in.err   = accept && !in_range;
    stage_in.rdata = (accept && !req_we && in_range) ? mem[mem_idx] : '0;
  end

  // Keeps shifting regardless of FSM state so refresh never delays a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage_in;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rsp_valid = pipe_q[LATENCY-1].vld;
  assign rsp_we    = pipe_q[LATENCY-1].we;
  assign rsp_err   = pipe_q[LATENCY-1].err;
  assign rsp_rdata = pipe_q[LATENCY-1].rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the driver queues expected responses at acceptance,
// an independent monitor pops and compares data, flags and arrival cycle on every rsp_valid.
module tb_mem_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_we;

  always #5 clk = ~clk;

  mem_responder #(
    .AW(32), .DW(32), .DEPTH(1024), .LATENCY(LAT),
    .REFRESH_PERIOD(8), .REFRESH_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_we(rsp_we)
  );

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] rdata;
    int          due;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks      = 0;
  int   failures    = 0;
  int   cyc         = 0;
  int   post_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: independent of the driver, samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rsp_valid) begin
        post_pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check({e.tag, "_we"},    rsp_we,    e.we);
          check({e.tag, "_err"},   rsp_err,   e.err);
          check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
          check({e.tag, "_cycle"}, cyc,       e.due);
        end
      end else begin
        check("rsp_idle_zero", {rsp_rdata, rsp_err, rsp_we}, 0);
      end
    end
  end

  // Called at a falling edge; holds the request until accepted, then returns one cycle later.
  task automatic issue(string tag, logic we, logic [31:0] addr, logic [31:0] wdata,
                       logic [3:0] wstrb, logic [31:0] exp_rd, logic exp_err);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check({tag, "_ready_timeout"}, 0, 1);
    else            exp_q.push_back('{we, exp_err, exp_rd, cyc + LAT, tag});
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
  endtask

  task automatic wait_drain(string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  bit rdy [40];
  bit rv  [40];

  initial begin
    int idx;
    int acc;
    int n;
    logic pattern_ok;

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_we, rsp_rdata}, 0);

    rst_n = 1'b1;
    #1 check("init_ready", req_ready, 0);
    @(negedge clk);
    check("normal_ready", req_ready, 1);

    // Write then read-after-write to the same word
    issue("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    issue("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Byte strobes: bytes 0 and 2 replaced
    issue("wr20_full", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
    issue("wr20_strb", 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0);
    issue("rd20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

    // Fill words 0..3, then back-to-back reads
    for (int i = 0; i < 4; i++)
      issue($sformatf("wr_w%0d", i), 1'b1, 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      issue($sformatf("rd_w%0d", i), 1'b0, 32'(4 * i), 32'h0, 4'h0, 32'hC0DE0000 + 32'(i), 1'b0);

    // Zero strobe writes nothing; byte-offset bits are ignored on reads
    issue("wr10_nostrb", 1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0, 1'b0);
    issue("rd13", 1'b0, 32'h13, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Last valid word and first out-of-range word (aliases word 0 if index were truncated)
    issue("wr_last", 1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
    issue("rd_last", 1'b0, 32'hFFC, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
    issue("wr_oor", 1'b1, 32'h1000, 32'h55555555, 4'hF, 32'h0, 1'b1);
    issue("rd_oor", 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
    issue("rd0_after_oor", 1'b0, 32'h0, 32'h0, 4'h0, 32'hC0DE0000, 1'b0);
    wait_drain("basic");

    // Refresh: hold req_valid high and record the ready pattern
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4;
    for (int k = 0; k < 36; k++) begin
      rdy[k] = req_ready;
      rv[k]  = rsp_valid;
      if (req_ready) exp_q.push_back('{1'b0, 1'b0, 32'hC0DE0001, cyc + LAT, "rd_refresh"});
      @(negedge clk);
    end
    req_valid = 1'b0; req_addr = '0;
    idx = -1;
    for (int k = 1; k <= 12; k++)
      if (idx < 0 && rdy[k-1] && !rdy[k]) idx = k;
    if (idx < 0) begin
      check("refresh_window_found", 0, 1);
    end else begin
      pattern_ok = 1'b1;
      acc = 0;
      for (int j = 0; j < 12; j++) begin
        if (j < 4 && rdy[idx + j])   pattern_ok = 1'b0;
        if (j >= 4 && !rdy[idx + j]) pattern_ok = 1'b0;
        if (rdy[idx + j]) acc++;
      end
      if (rdy[idx + 12]) pattern_ok = 1'b0;
      check("refresh_pattern_8on_4off", pattern_ok, 1);
      check("refresh_accepts_per_12", acc, 8);
      check("last_normal_rsp_in_refresh", rv[idx + 2], 1);
    end
    wait_drain("refresh");

    // Reset with three reads in flight
    issue("rd_inflight0", 1'b0, 32'h0, 32'h0, 4'h0, 32'hC0DE0000, 1'b0);
    issue("rd_inflight1", 1'b0, 32'h4, 32'h0, 4'h0, 32'hC0DE0001, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("inflight2_ready", req_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0;
    #1 check("async_rst_outputs", {req_ready, rsp_valid, rsp_rdata}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    post_pulses = 0;
    repeat (10) @(negedge clk);
    check("no_rsp_after_rst", post_pulses, 0);
    issue("rd10_after_rst", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    wait_drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side endpoint of the shared memory request/response interface; sits below the round-robin arbiter in place of the L2 and models it for block-level and integration testing.
- Accepts one request per cycle and returns each response a fixed LATENCY cycles later, in order.
- Backing store is a word array; periodic refresh windows deassert ready to exercise requester stall paths.
- The top-level wrapper packs and unpacks these flat ports into mem_req_t / mem_resp_t.

Parameters:
- AW, 32, byte address width
- DW, 32, data width; power of two, at least 8
- DEPTH, 1024, number of DW-bit words in the backing store
- LATENCY, 3, cycles from acceptance to rsp_valid; at least 1
- REFRESH_PERIOD, 64, NORMAL cycles between refresh windows; 0 disables refresh
- REFRESH_CYCLES, 4, length of each refresh window in cycles; at least 1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  byte address
- req_wdata  in  DW  write data
- req_wstrb  in  DW/8  byte-enable mask for writes
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- rsp_valid  out  1  response valid; single-cycle pulse, no backpressure
- rsp_rdata  out  DW  read data; 0 for writes and errors
- rsp_err  out  1  address out of range
- rsp_we  out  1  echo of the request type

Behaviour:
- Reset is asynchronous and active-low; clock is clk.
- While reset is asserted: FSM = INIT; all pipeline valids cleared; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_we=0; refresh counter=0.
- Memory contents are not reset.
- FSM states:
  - INIT: exactly 1 cycle after reset release, then NORMAL.
  - NORMAL: req_ready=1. The refresh counter increments every NORMAL cycle. When REFRESH_PERIOD!=0 and the counter equals REFRESH_PERIOD-1, go to REFRESH next cycle and clear the counter. A request in that last NORMAL cycle is still accepted.
  - REFRESH: req_ready=0 for exactly REFRESH_CYCLES cycles, then NORMAL.
- req_ready is a combinational decode of state only; it never depends on req_valid.
- Acceptance happens at cycle T when req_valid && req_ready at the posedge.
- Word index = req_addr >> log2(DW/8); low byte-offset bits are ignored. Index >= DEPTH means error.
- Read:
  - The array is read at acceptance, and data enters a LATENCY-deep shift pipeline.
  - rsp_valid=1 with rsp_rdata in cycle T+LATENCY.
- Write:
  - Bytes with req_wstrb set are committed at the T posedge; wstrb=0 writes nothing.
  - A response is still returned at T+LATENCY with rsp_we=1 and rsp_rdata=0.
- Error: rsp_err=1 and rsp_rdata=0 at T+LATENCY; the write is dropped; memory is unchanged.
- Read-after-write: a read accepted at T+1 to the same word returns the data written at T.
- Responses leave in acceptance order. Throughput is 1 per cycle, so up to LATENCY responses are in flight.
- The pipeline keeps draining during REFRESH; responses are never lost or delayed by refresh.
- rsp_* outputs are registered (last pipeline stage). When rsp_valid=0, rsp_rdata, rsp_err and rsp_we are 0.
- Reset mid-operation discards all in-flight responses; no rsp_valid pulses after release until new acceptances.
- The refresh counter does not advance in INIT or REFRESH.

Test Plan:
- Reset release, LATENCY=3 → req_ready=0 in first cycle, 1 in second. Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF accepted at T → rsp_valid at T+3, rsp_we=1, rdata=0. Read 0x10 accepted at T+1 → rsp_valid at T+4, rdata=0xDEADBEEF.
- Byte strobes: write 0x11223344 full, then write 0xAABBCCDD with wstrb 0x5, then read → rdata=0x11BB33DD.
- Back-to-back reads of addrs 0x0,0x4,0x8,0xC on 4 consecutive cycles → 4 consecutive rsp_valid cycles, data in order, no gaps.
- Out of range, DEPTH=1024: write then read addr 0x1000 → both rsp_err=1, rdata=0; memory word 0 unchanged.
- Refresh, PERIOD=8, CYCLES=4:
  - req_valid held high continuously → req_ready is 1 for 8 cycles, 0 for 4, repeating.
  - Exactly 8 acceptances per 12-cycle window.
  - A request accepted in the last NORMAL cycle still responds at +LATENCY during REFRESH.
- Reset asserted with 3 reads in flight → no rsp_valid after release. A following read of a previously written word returns its pre-reset value, since memory is not reset.
